vga_timing_gen: RTL and testbench

- Produces the pixel raster (xpos/ypos) and VGA sync for 640x480@60 Hz from the 25 MHz pixel clock.
- Consumes the 8-bit colour computed combinationally by the game block from xpos/ypos, then drives the VGA connector.
- Registers colour, forces it to black in blanking, and delays hsync/vsync so sync and colour leave the FPGA on the same cycle for the same pixel.
- Also provides a frame-end strobe and a frame counter.

---
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator and VGA output stage: pixel counters, sync decode, and a
// colour/sync alignment pipeline so sync and blanked colour leave on the same cycle.
module vga_timing_gen #(
    parameter int unsigned H_VIS     = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VIS     = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned COLOR_LAT = 0
) (
    input  logic        clk25,
    input  logic        Reset,
    input  logic [2:0]  red_in,
    input  logic [2:0]  green_in,
    input  logic [1:0]  blue_in,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic        visible,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  vga_red,
    output logic [2:0]  vga_green,
    output logic [1:0]  vga_blue,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned LAT   = COLOR_LAT + 1;

    localparam logic [9:0] XLast   = 10'(H_TOT - 1);
    localparam logic [9:0] YLast   = 10'(V_TOT - 1);
    localparam logic [9:0] XVis    = 10'(H_VIS);
    localparam logic [9:0] YVis    = 10'(V_VIS);
    localparam logic [9:0] HsStart = 10'(H_VIS + H_FP);
    localparam logic [9:0] HsEnd   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VsStart = 10'(V_VIS + V_FP);
    localparam logic [9:0] VsEnd   = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0]  xpos_q, ypos_q;
    logic        hs_raw, vs_raw, frame_end;
    logic        frame_tick_q;
    logic [15:0] frame_count_q;
    logic [2:0]  red_q, green_q;
    logic [1:0]  blue_q;

    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            xpos_q <= '0;
            ypos_q <= '0;
        end else if (xpos_q == XLast) begin
            xpos_q <= '0;
            ypos_q <= (ypos_q == YLast) ? '0 : ypos_q + 10'd1;
        end else begin
            xpos_q <= xpos_q + 10'd1;
        end
    end

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign visible   = (xpos_q < XVis) && (ypos_q < YVis);
    assign hs_raw    = (xpos_q >= HsStart) && (xpos_q < HsEnd);
    assign vs_raw    = (ypos_q >= VsStart) && (ypos_q < VsEnd);
    assign frame_end = (xpos_q == 10'd0) && (ypos_q == YVis);

    // Sync pipeline holds active-high flags; index 0 is the undelayed decode.
    logic [LAT:1] hs_q, vs_q;
    logic [LAT:0] hs_d, vs_d;

    assign hs_d = {hs_q, hs_raw};
    assign vs_d = {vs_q, vs_raw};

    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            hs_q <= '0;
            vs_q <= '0;
        end else begin
            hs_q <= hs_d[LAT-1:0];
            vs_q <= vs_d[LAT-1:0];
        end
    end

    assign hsync = hs_d[LAT] ? SYNC_POL : ~SYNC_POL;
    assign vsync = vs_d[LAT] ? SYNC_POL : ~SYNC_POL;

    // Visible is delayed to match the upstream colour latency; the colour register is the
    // final stage, so the whole path is LAT deep like the sync pipeline.
    logic [COLOR_LAT:0] vis_d;

    if (COLOR_LAT > 0) begin : g_vis_pipe
        logic [COLOR_LAT:1] vis_q;

        always_ff @(posedge clk25 or posedge Reset) begin
            if (Reset) begin
                vis_q <= '0;
            end else begin
                vis_q <= vis_d[COLOR_LAT-1:0];
            end
        end

        assign vis_d = {vis_q, visible};
    end else begin : g_vis_direct
        assign vis_d = visible;
    end

    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (vis_d[COLOR_LAT]) begin
            red_q   <= red_in;
            green_q <= green_in;
            blue_q  <= blue_in;
        end else begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end
    end

    assign vga_red   = red_q;
    assign vga_green = green_q;
    assign vga_blue  = blue_q;

    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            frame_tick_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_tick_q <= frame_end;
            if (frame_end) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus two reduced rasters (colour latency 0
// and 2, both sync polarities), compared cycle by cycle with an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int NI = 3;

    typedef struct {
        int hvis, hfp, hsync, hbp;
        int vvis, vfp, vsync, vbp;
        int clat;
        bit pol;
    } cfg_t;

    logic clk25 = 1'b0;
    logic Reset = 1'b1;

    logic [2:0]  red_in[NI], green_in[NI], vga_red[NI], vga_green[NI];
    logic [1:0]  blue_in[NI], vga_blue[NI];
    logic [9:0]  xpos[NI], ypos[NI];
    logic        visible[NI], hsync[NI], vsync[NI], frame_tick[NI];
    logic [15:0] frame_count[NI];

    cfg_t       cfg[NI];
    int         k;
    int         n_assert, n_fail;
    int         fc_exp[NI];
    logic [7:0] in_hist[NI][0:4095];

    always #20 clk25 = ~clk25;

    vga_timing_gen #(
        .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VIS(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .SYNC_POL(1'b0), .COLOR_LAT(0)
    ) u_full (
        .clk25(clk25), .Reset(Reset),
        .red_in(red_in[0]), .green_in(green_in[0]), .blue_in(blue_in[0]),
        .xpos(xpos[0]), .ypos(ypos[0]), .visible(visible[0]),
        .hsync(hsync[0]), .vsync(vsync[0]),
        .vga_red(vga_red[0]), .vga_green(vga_green[0]), .vga_blue(vga_blue[0]),
        .frame_tick(frame_tick[0]), .frame_count(frame_count[0])
    );

    vga_timing_gen #(
        .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0), .COLOR_LAT(0)
    ) u_small0 (
        .clk25(clk25), .Reset(Reset),
        .red_in(red_in[1]), .green_in(green_in[1]), .blue_in(blue_in[1]),
        .xpos(xpos[1]), .ypos(ypos[1]), .visible(visible[1]),
        .hsync(hsync[1]), .vsync(vsync[1]),
        .vga_red(vga_red[1]), .vga_green(vga_green[1]), .vga_blue(vga_blue[1]),
        .frame_tick(frame_tick[1]), .frame_count(frame_count[1])
    );

    vga_timing_gen #(
        .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1), .COLOR_LAT(2)
    ) u_small2 (
        .clk25(clk25), .Reset(Reset),
        .red_in(red_in[2]), .green_in(green_in[2]), .blue_in(blue_in[2]),
        .xpos(xpos[2]), .ypos(ypos[2]), .visible(visible[2]),
        .hsync(hsync[2]), .vsync(vsync[2]),
        .vga_red(vga_red[2]), .vga_green(vga_green[2]), .vga_blue(vga_blue[2]),
        .frame_tick(frame_tick[2]), .frame_count(frame_count[2])
    );

    function automatic int htot(input cfg_t c);
        return c.hvis + c.hfp + c.hsync + c.hbp;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.vvis + c.vfp + c.vsync + c.vbp;
    endfunction

    // Raster position of the n-th pixel after reset release.
    function automatic int px(input cfg_t c, input int n);
        return n % htot(c);
    endfunction

    function automatic int py(input cfg_t c, input int n);
        return (n / htot(c)) % vtot(c);
    endfunction

    function automatic logic vis_at(input cfg_t c, input int n);
        return (px(c, n) < c.hvis) && (py(c, n) < c.vvis);
    endfunction

    function automatic logic tick_at(input cfg_t c, input int n);
        return (n >= 1) && (px(c, n - 1) == 0) && (py(c, n - 1) == c.vvis);
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst%0d k=%0d observed=%0h expected=%0h", tag, i, k, obs, exp);
        end
    endtask

    task automatic check_inst(input int i);
        cfg_t c;
        int lat, m, mx, my;
        logic ev, ehs, evs, eh, ee;
        logic [7:0] ecol;
        c   = cfg[i];
        lat = c.clat + 1;
        ev  = 1'b0;
        ehs = 1'b0;
        evs = 1'b0;
        if (k >= lat) begin
            m   = k - lat;
            mx  = px(c, m);
            my  = py(c, m);
            ev  = vis_at(c, m);
            ehs = (mx >= c.hvis + c.hfp) && (mx < c.hvis + c.hfp + c.hsync);
            evs = (my >= c.vvis + c.vfp) && (my < c.vvis + c.vfp + c.vsync);
        end
        ecol = 8'd0;
        if (ev) ecol = in_hist[i][k-1];
        chk("xpos", i, 32'(xpos[i]), 32'(px(c, k)));
        chk("ypos", i, 32'(ypos[i]), 32'(py(c, k)));
        chk("visible", i, 32'(visible[i]), 32'(vis_at(c, k)));
        eh = ehs ? c.pol : !c.pol;
        chk("hsync", i, 32'(hsync[i]), 32'(eh));
        ee = evs ? c.pol : !c.pol;
        chk("vsync", i, 32'(vsync[i]), 32'(ee));
        chk("vga_red", i, 32'(vga_red[i]), 32'(ecol[7:5]));
        chk("vga_green", i, 32'(vga_green[i]), 32'(ecol[4:2]));
        chk("vga_blue", i, 32'(vga_blue[i]), 32'(ecol[1:0]));
        chk("frame_tick", i, 32'(frame_tick[i]), 32'(tick_at(c, k)));
        chk("frame_count", i, 32'(frame_count[i]), 32'(fc_exp[i]));
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) check_inst(i);
    endtask

    // Random colour; with extra colour latency, red[2] mimics a game that registers
    // xpos[0] clat times, so it must toggle with the delayed pixel index.
    task automatic drive();
        logic [7:0] col;
        for (int i = 0; i < NI; i++) begin
            col = 8'($urandom);
            if (cfg[i].clat > 0 && k >= cfg[i].clat) begin
                col[7] = (px(cfg[i], k - cfg[i].clat) % 2) == 1;
            end
            in_hist[i][k] = col;
            red_in[i]     = col[7:5];
            green_in[i]   = col[4:2];
            blue_in[i]    = col[1:0];
        end
    endtask

    task automatic step();
        @(posedge clk25);
        k++;
        for (int i = 0; i < NI; i++) begin
            if (tick_at(cfg[i], k)) fc_exp[i] = (fc_exp[i] + 1) % 65536;
        end
        @(negedge clk25);
        check_all();
        drive();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        k        = 0;
        cfg[0] = '{hvis: 640, hfp: 16, hsync: 96, hbp: 48, vvis: 480, vfp: 10, vsync: 2,
                   vbp: 33, clat: 0, pol: 1'b0};
        cfg[1] = '{hvis: 16, hfp: 4, hsync: 6, hbp: 6, vvis: 12, vfp: 2, vsync: 2,
                   vbp: 3, clat: 0, pol: 1'b0};
        cfg[2] = '{hvis: 16, hfp: 4, hsync: 6, hbp: 6, vvis: 12, vfp: 2, vsync: 2,
                   vbp: 3, clat: 2, pol: 1'b1};
        for (int i = 0; i < NI; i++) fc_exp[i] = 0;
        Reset = 1'b1;
        drive();

        // Reset held for five cycles: everything stays at its reset value.
        repeat (5) begin
            @(negedge clk25);
            check_all();
            drive();
        end

        // Release, then run two lines of the full raster and three small frames.
        @(negedge clk25);
        Reset = 1'b0;
        check_all();
        drive();
        repeat (1900) step();

        // Asynchronous reset between edges, mid-line and mid-frame.
        #5 Reset = 1'b1;
        #1;
        k = 0;
        for (int i = 0; i < NI; i++) fc_exp[i] = 0;
        check_all();
        repeat (3) begin
            @(negedge clk25);
            check_all();
            drive();
        end

        // Raster restarts at (0,0) and counts frames afresh.
        @(negedge clk25);
        Reset = 1'b0;
        check_all();
        drive();
        repeat (1300) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
